// File: rtl/hazard_control_unit_if.sv
// Purpose : bundles the hazard-detection inputs and control outputs of the 5-stage core.
// Latency : none; plain wires between the pipeline datapath and the hazard unit.
// Backpressure: stall/flush outputs are the pipeline's only hold mechanism; no handshake.
// Modports: master = pipeline datapath (drives register fields/enables, consumes controls),
//           slave  = hazard_control_unit (consumes fields/enables, drives controls).
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       RsD, RtD, RsE, RtE;
  logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemToRegE, MemToRegM;
  logic             BranchD, PCSrcD, MultiCycleE;

  logic             StallF, StallD, StallE;
  logic             FlushD, FlushE, FlushM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             ForwardAD, ForwardBD;
  logic             mc_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM,
           BranchD, PCSrcD, MultiCycleE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, mc_busy, stall_cycles
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM,
           BranchD, PCSrcD, MultiCycleE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, ForwardAD, ForwardBD, mc_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Purpose : stall/flush/forward control for the 5-stage core plus a mul/div hold sequencer.
// Latency : combinational from current inputs and registered sequencer state; no added delay.
// Backpressure: holds PC/IF-ID (and ID-EX for multi-cycle ops) via StallF/D/E; bubbles via Flush*.
// Ports: clk, rst_n (async active-low); hif (slave modport) carries all hazard inputs and
//        control outputs, including mc_busy and the saturating stall_cycles counter.
module hazard_control_unit #(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_control_unit_if.slave hif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  // Entry cycle counts as the first EX cycle, so BUSY lasts MC_LATENCY-1 cycles.
  localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY - 1);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             mc_busy_q;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic       lwstall, brstall, hz_stall, mc_stall;
  logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
  logic [1:0] fwd_ae, fwd_be;
  logic       fwd_ad, fwd_bd;

  // Register 0 is hardwired, so a match on it never constitutes a dependency.
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  assign lwstall  = hif.MemToRegE && (hit(hif.RtE, hif.RsD) || hit(hif.RtE, hif.RtD));
  assign brstall  = hif.BranchD &&
                    ((hif.RegWriteE && (hit(hif.WriteRegE, hif.RsD) || hit(hif.WriteRegE, hif.RtD))) ||
                     (hif.MemToRegM && (hit(hif.WriteRegM, hif.RsD) || hit(hif.WriteRegM, hif.RtD))));
  assign hz_stall = lwstall || brstall;

  // The entry cycle stalls combinationally; the last BUSY cycle (cnt==1) releases the pipe.
  assign mc_stall = (state_q == IDLE) ? hif.MultiCycleE : (cnt_q != 4'd1);

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (mc_stall) begin
      // Keep the op parked in ID/EX and feed bubbles downstream; other hazards wait.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else begin
      stall_f = hz_stall;
      stall_d = hz_stall;
      flush_e = hz_stall;
    end
    // A taken branch that is still waiting on its operands must not redirect yet.
    flush_d = hif.PCSrcD && !stall_d;

    // MEM result is younger than WB, so it wins.
    if (hif.RegWriteM && hit(hif.WriteRegM, hif.RsE))      fwd_ae = 2'b10;
    else if (hif.RegWriteW && hit(hif.WriteRegW, hif.RsE)) fwd_ae = 2'b01;
    else                                                   fwd_ae = 2'b00;
    if (hif.RegWriteM && hit(hif.WriteRegM, hif.RtE))      fwd_be = 2'b10;
    else if (hif.RegWriteW && hit(hif.WriteRegW, hif.RtE)) fwd_be = 2'b01;
    else                                                   fwd_be = 2'b00;
    fwd_ad = hif.RegWriteM && hit(hif.WriteRegM, hif.RsD);
    fwd_bd = hif.RegWriteM && hit(hif.WriteRegM, hif.RtD);

    // Quiet control outputs for as long as reset is held.
    if (!rst_n) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      fwd_ae  = 2'b00;
      fwd_be  = 2'b00;
      fwd_ad  = 1'b0;
      fwd_bd  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      mc_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hif.MultiCycleE) begin
            state_q   <= BUSY;
            cnt_q     <= MC_LOAD;
            mc_busy_q <= 1'b1;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q   <= IDLE;
            mc_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mc_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturate rather than wrap so long runs still read as "at least this many".
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_f && (stall_cycles_q != {CNT_W{1'b1}})) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign hif.StallF       = stall_f;
  assign hif.StallD       = stall_d;
  assign hif.StallE       = stall_e;
  assign hif.FlushD       = flush_d;
  assign hif.FlushE       = flush_e;
  assign hif.FlushM       = flush_m;
  assign hif.ForwardAE    = fwd_ae;
  assign hif.ForwardBE    = fwd_be;
  assign hif.ForwardAD    = fwd_ad;
  assign hif.ForwardBD    = fwd_bd;
  assign hif.mc_busy      = mc_busy_q;
  assign hif.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Purpose : scoreboard bench for hazard_control_unit (MC_LATENCY=4, CNT_W=4).
// Latency : inputs driven 1ns after posedge, outputs compared on the following negedge.
// Backpressure: n/a; stall/flush outputs are compared as part of each expected vector.
module tb_hazard_control_unit;

  logic clk;
  logic rst_n;

  hazard_control_unit_if #(.CNT_W(4)) hif ();

  hazard_control_unit #(.MC_LATENCY(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, BranchD, PCSrcD, MultiCycleE;
  } in_t;

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM}, ForwardAE, ForwardBE, {ForwardAD,ForwardBD,mc_busy}, count
  typedef struct packed {
    logic [5:0] sfm;
    logic [1:0] ae;
    logic [1:0] be;
    logic [2:0] misc;
    logic [3:0] sc;
  } out_t;

  out_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [3:0] exp_sc = 4'd0;

  task automatic apply(input in_t s);
    hif.RsD = s.RsD;             hif.RtD = s.RtD;
    hif.RsE = s.RsE;             hif.RtE = s.RtE;
    hif.WriteRegE = s.WriteRegE; hif.WriteRegM = s.WriteRegM; hif.WriteRegW = s.WriteRegW;
    hif.RegWriteE = s.RegWriteE; hif.RegWriteM = s.RegWriteM; hif.RegWriteW = s.RegWriteW;
    hif.MemToRegE = s.MemToRegE; hif.MemToRegM = s.MemToRegM;
    hif.BranchD = s.BranchD;     hif.PCSrcD = s.PCSrcD;       hif.MultiCycleE = s.MultiCycleE;
  endtask

  function automatic out_t observe();
    out_t o;
    o.sfm  = {hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE, hif.FlushM};
    o.ae   = hif.ForwardAE;
    o.be   = hif.ForwardBE;
    o.misc = {hif.ForwardAD, hif.ForwardBD, hif.mc_busy};
    o.sc   = hif.stall_cycles;
    return o;
  endfunction

  task automatic test_reset();
    in_t s; out_t e, got;
    rst_n = 1'b0;
    s = '0; s.MemToRegE = 1'b1; s.RtE = 5'd5; s.RsD = 5'd5; s.PCSrcD = 1'b1;
    s.RegWriteM = 1'b1; s.WriteRegM = 5'd6; s.RsE = 5'd6; s.MultiCycleE = 1'b1;
    apply(s);
    exp_q.push_back(out_t'(0));
    @(negedge clk); got = observe(); e = exp_q.pop_front(); n_assert++;
    if (got !== e) begin n_fail++; $display("FAIL reset_held: got %b expected %b", got, e); end
    @(posedge clk); #1;
    s = '0; apply(s); rst_n = 1'b1; exp_sc = 4'd0;
    exp_q.push_back(out_t'(0));
    @(negedge clk); got = observe(); e = exp_q.pop_front(); n_assert++;
    if (got !== e) begin n_fail++; $display("FAIL reset_release: got %b expected %b", got, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    in_t s; in_t ins[$]; out_t exps[$]; out_t e, got;
    s = '0; s.MemToRegE = 1'b1; s.RtE = 5'd5; s.RsD = 5'd5;
    ins.push_back(s); exps.push_back({6'b110010, 2'b00, 2'b00, 3'b000, 4'h0});
    s = '0;
    ins.push_back(s); exps.push_back({6'b000000, 2'b00, 2'b00, 3'b000, 4'h0});
    s = '0; s.MemToRegE = 1'b1;                       // RtE = RsD = 0
    ins.push_back(s); exps.push_back({6'b000000, 2'b00, 2'b00, 3'b000, 4'h0});
    s = '0; s.MemToRegE = 1'b1; s.RtE = 5'd7; s.RtD = 5'd7; s.PCSrcD = 1'b1;
    ins.push_back(s); exps.push_back({6'b110010, 2'b00, 2'b00, 3'b000, 4'h0});
    s = '0; s.PCSrcD = 1'b1;
    ins.push_back(s); exps.push_back({6'b000100, 2'b00, 2'b00, 3'b000, 4'h0});
    s = '0;
    ins.push_back(s); exps.push_back({6'b000000, 2'b00, 2'b00, 3'b000, 4'h0});
    foreach (ins[k]) begin
      apply(ins[k]); e = exps[k]; e.sc = exp_sc; exp_q.push_back(e);
      @(negedge clk); got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin n_fail++; $display("FAIL load_use step %0d: got %b expected %b", k, got, e); end
      if (e.sfm[5]) exp_sc = (exp_sc == 4'hF) ? 4'hF : exp_sc + 4'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forward();
    in_t s; in_t ins[$]; out_t exps[$]; out_t e, got;
    s = '0; s.RegWriteM = 1'b1; s.RegWriteW = 1'b1; s.WriteRegM = 5'd8; s.WriteRegW = 5'd8;
    s.RsE = 5'd8; s.RtE = 5'd8;
    ins.push_back(s); exps.push_back({6'b000000, 2'b10, 2'b10, 3'b000, 4'h0});
    s.RegWriteM = 1'b0;
    ins.push_back(s); exps.push_back({6'b000000, 2'b01, 2'b01, 3'b000, 4'h0});
    s = '0; s.RegWriteM = 1'b1; s.WriteRegM = 5'd8; s.RsE = 5'd8;
    s.RegWriteW = 1'b1; s.WriteRegW = 5'd9; s.RtE = 5'd9;
    ins.push_back(s); exps.push_back({6'b000000, 2'b10, 2'b01, 3'b000, 4'h0});
    s = '0; s.RegWriteM = 1'b1; s.RegWriteW = 1'b1;     // everything on r0
    ins.push_back(s); exps.push_back({6'b000000, 2'b00, 2'b00, 3'b000, 4'h0});
    s = '0; s.RegWriteM = 1'b1; s.WriteRegM = 5'd9; s.RsD = 5'd9; s.RtD = 5'd9;
    ins.push_back(s); exps.push_back({6'b000000, 2'b00, 2'b00, 3'b110, 4'h0});
    s.RegWriteM = 1'b0;
    ins.push_back(s); exps.push_back({6'b000000, 2'b00, 2'b00, 3'b000, 4'h0});
    foreach (ins[k]) begin
      apply(ins[k]); e = exps[k]; e.sc = exp_sc; exp_q.push_back(e);
      @(negedge clk); got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin n_fail++; $display("FAIL forward step %0d: got %b expected %b", k, got, e); end
      if (e.sfm[5]) exp_sc = (exp_sc == 4'hF) ? 4'hF : exp_sc + 4'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    in_t s; in_t ins[$]; out_t exps[$]; out_t e, got;
    s = '0; s.BranchD = 1'b1; s.RegWriteE = 1'b1; s.WriteRegE = 5'd3; s.RsD = 5'd3; s.PCSrcD = 1'b1;
    ins.push_back(s); exps.push_back({6'b110010, 2'b00, 2'b00, 3'b000, 4'h0});
    s = '0; s.BranchD = 1'b1; s.RsD = 5'd3; s.RegWriteM = 1'b1; s.WriteRegM = 5'd3; s.PCSrcD = 1'b1;
    ins.push_back(s); exps.push_back({6'b000100, 2'b00, 2'b00, 3'b100, 4'h0});
    s = '0; s.BranchD = 1'b1; s.MemToRegM = 1'b1; s.RegWriteM = 1'b1; s.WriteRegM = 5'd4; s.RtD = 5'd4;
    ins.push_back(s); exps.push_back({6'b110010, 2'b00, 2'b00, 3'b010, 4'h0});
    s = '0; s.RegWriteE = 1'b1; s.WriteRegE = 5'd3; s.RsD = 5'd3;   // not a branch
    ins.push_back(s); exps.push_back({6'b000000, 2'b00, 2'b00, 3'b000, 4'h0});
    s = '0; s.BranchD = 1'b1; s.RegWriteE = 1'b1;                    // r0 only
    ins.push_back(s); exps.push_back({6'b000000, 2'b00, 2'b00, 3'b000, 4'h0});
    foreach (ins[k]) begin
      apply(ins[k]); e = exps[k]; e.sc = exp_sc; exp_q.push_back(e);
      @(negedge clk); got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin n_fail++; $display("FAIL branch step %0d: got %b expected %b", k, got, e); end
      if (e.sfm[5]) exp_sc = (exp_sc == 4'hF) ? 4'hF : exp_sc + 4'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multicycle();
    in_t s; in_t ins[$]; out_t exps[$]; out_t e, got;
    s = '0; s.MultiCycleE = 1'b1;
    ins.push_back(s); exps.push_back({6'b111001, 2'b00, 2'b00, 3'b000, 4'h0});
    s = '0; s.MemToRegE = 1'b1; s.RtE = 5'd5; s.RsD = 5'd5; s.PCSrcD = 1'b1;   // masked by op
    ins.push_back(s); exps.push_back({6'b111001, 2'b00, 2'b00, 3'b001, 4'h0});
    s.PCSrcD = 1'b0; s.MultiCycleE = 1'b1;                                      // ignored while busy
    ins.push_back(s); exps.push_back({6'b111001, 2'b00, 2'b00, 3'b001, 4'h0});
    s.MultiCycleE = 1'b0;                                                       // release: load-use seen
    ins.push_back(s); exps.push_back({6'b110010, 2'b00, 2'b00, 3'b001, 4'h0});
    s = '0;
    ins.push_back(s); exps.push_back({6'b000000, 2'b00, 2'b00, 3'b000, 4'h0});
    foreach (ins[k]) begin
      apply(ins[k]); e = exps[k]; e.sc = exp_sc; exp_q.push_back(e);
      @(negedge clk); got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin n_fail++; $display("FAIL multicycle step %0d: got %b expected %b", k, got, e); end
      if (e.sfm[5]) exp_sc = (exp_sc == 4'hF) ? 4'hF : exp_sc + 4'd1;
      @(posedge clk); #1;
    end
  endtask

  // Two ops back to back: 3 stall cycles each, busy during the last 3 cycles of each op.
  task automatic test_back_to_back();
    in_t s; out_t e, got;
    logic stl, busy;
    for (int k = 0; k < 9; k++) begin
      s = '0; s.MultiCycleE = (k < 8);
      stl  = (k < 8) && ((k % 4) != 3);
      busy = (k < 8) && ((k % 4) != 0);
      apply(s);
      e = {stl ? 6'b111001 : 6'b000000, 2'b00, 2'b00, {2'b00, busy}, exp_sc};
      exp_q.push_back(e);
      @(negedge clk); got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin n_fail++; $display("FAIL back_to_back step %0d: got %b expected %b", k, got, e); end
      if (e.sfm[5]) exp_sc = (exp_sc == 4'hF) ? 4'hF : exp_sc + 4'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_op();
    in_t s; out_t e, got;
    for (int k = 0; k < 2; k++) begin
      s = '0; s.MultiCycleE = (k == 0);
      apply(s);
      e = {6'b111001, 2'b00, 2'b00, {2'b00, (k == 1)}, exp_sc};
      exp_q.push_back(e);
      @(negedge clk); got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin n_fail++; $display("FAIL mid_op_setup step %0d: got %b expected %b", k, got, e); end
      if (e.sfm[5]) exp_sc = (exp_sc == 4'hF) ? 4'hF : exp_sc + 4'd1;
      @(posedge clk); #1;
    end
    // Second BUSY cycle: pull reset with live hazards present.
    s = '0; s.MemToRegE = 1'b1; s.RtE = 5'd5; s.RsD = 5'd5; s.RegWriteM = 1'b1; s.WriteRegM = 5'd5;
    s.PCSrcD = 1'b1;
    apply(s); rst_n = 1'b0; exp_sc = 4'd0;
    exp_q.push_back(out_t'(0));
    #1; got = observe(); e = exp_q.pop_front(); n_assert++;
    if (got !== e) begin n_fail++; $display("FAIL mid_op_async_reset: got %b expected %b", got, e); end
    @(posedge clk); #1;
    s = '0; apply(s); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(out_t'(0));
      @(negedge clk); got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin n_fail++; $display("FAIL mid_op_no_resume step %0d: got %b expected %b", k, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    in_t s; out_t e, got;
    for (int k = 0; k < 22; k++) begin
      s = '0;
      if (k < 20) begin s.MemToRegE = 1'b1; s.RtE = 5'd5; s.RsD = 5'd5; end
      apply(s);
      e = {(k < 20) ? 6'b110010 : 6'b000000, 2'b00, 2'b00, 3'b000, exp_sc};
      exp_q.push_back(e);
      @(negedge clk); got = observe(); e = exp_q.pop_front(); n_assert++;
      if (got !== e) begin n_fail++; $display("FAIL saturation step %0d: got %b expected %b", k, got, e); end
      if (e.sfm[5]) exp_sc = (exp_sc == 4'hF) ? 4'hF : exp_sc + 4'd1;
      @(posedge clk); #1;
    end
    n_assert++;
    if (hif.stall_cycles !== 4'hF) begin
      n_fail++; $display("FAIL saturation_final: got %0d expected 15", hif.stall_cycles);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_multicycle();
    test_back_to_back();
    test_reset_mid_op();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
